// File: rtl/axis_hdr_insert_arbiter.sv
// Packet-level round-robin arbiter feeding a header-insert block.
// One requester is granted per packet: its header first, then its payload through last.
module axis_hdr_insert_arbiter #(
   parameter int unsigned DATA_WD      = 32,
   parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
   parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_WD        = $clog2(NUM_CH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_CH-1:0]                s_hdr_valid,
   input  logic [NUM_CH*DATA_WD-1:0]        s_hdr_data,
   input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_hdr_keep,
   input  logic [NUM_CH*BYTE_CNT_WD-1:0]    s_hdr_cnt,
   output logic [NUM_CH-1:0]                s_hdr_ready,
   input  logic [NUM_CH-1:0]                s_valid,
   input  logic [NUM_CH*DATA_WD-1:0]        s_data,
   input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_keep,
   input  logic [NUM_CH-1:0]                s_last,
   output logic [NUM_CH-1:0]                s_ready,
   output logic                             valid_insert,
   output logic [DATA_WD-1:0]               data_insert,
   output logic [DATA_BYTE_WD-1:0]          keep_insert,
   output logic [BYTE_CNT_WD-1:0]           byte_insert_cnt,
   input  logic                             ready_insert,
   output logic                             valid_in,
   output logic [DATA_WD-1:0]               data_in,
   output logic [DATA_BYTE_WD-1:0]          keep_in,
   output logic                             last_in,
   input  logic                             ready_in,
   output logic [CH_WD-1:0]                 grant_id,
   output logic                             busy,
   output logic                             pkt_done
);

   localparam int unsigned SUM_WD = CH_WD + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CH_WD-1:0]   grant_q, grant_d;
   logic [CH_WD-1:0]   rr_q, rr_d;
   logic               done_q, done_d;
   logic               arb_found;
   logic [CH_WD-1:0]   arb_idx;
   logic [SUM_WD-1:0]  arb_sum;

   logic [DATA_WD-1:0]      hdr_data_a [NUM_CH];
   logic [DATA_BYTE_WD-1:0] hdr_keep_a [NUM_CH];
   logic [BYTE_CNT_WD-1:0]  hdr_cnt_a  [NUM_CH];
   logic [DATA_WD-1:0]      data_a     [NUM_CH];
   logic [DATA_BYTE_WD-1:0] keep_a     [NUM_CH];

   // Split the flat per-channel buses into arrays indexed by channel
   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign hdr_data_a[g] = s_hdr_data[g*DATA_WD +: DATA_WD];
      assign hdr_keep_a[g] = s_hdr_keep[g*DATA_BYTE_WD +: DATA_BYTE_WD];
      assign hdr_cnt_a[g]  = s_hdr_cnt[g*BYTE_CNT_WD +: BYTE_CNT_WD];
      assign data_a[g]     = s_data[g*DATA_WD +: DATA_WD];
      assign keep_a[g]     = s_keep[g*DATA_BYTE_WD +: DATA_BYTE_WD];
   end

   // Round-robin pick: first requesting channel at or after rr_q, wrapping at NUM_CH
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_sum   = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         arb_sum = {1'b0, rr_q} + SUM_WD'(k);
         if (arb_sum >= SUM_WD'(NUM_CH)) begin
            arb_sum = arb_sum - SUM_WD'(NUM_CH);
         end
         if (!arb_found && s_hdr_valid[arb_sum[CH_WD-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_sum[CH_WD-1:0];
         end
      end
   end

   // Data fields simply follow the registered grant
   assign data_insert     = hdr_data_a[grant_q];
   assign keep_insert     = hdr_keep_a[grant_q];
   assign byte_insert_cnt = hdr_cnt_a[grant_q];
   assign data_in         = data_a[grant_q];
   assign keep_in         = keep_a[grant_q];
   assign last_in         = s_last[grant_q];
   assign grant_id        = grant_q;
   assign busy            = (state_q != ST_IDLE);
   assign pkt_done        = done_q;

   // Next-state, grant bookkeeping and handshake steering
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_d         = rr_q;
      done_d       = 1'b0;
      valid_insert = 1'b0;
      valid_in     = 1'b0;
      s_hdr_ready  = '0;
      s_ready      = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               grant_d = arb_idx;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            valid_insert         = s_hdr_valid[grant_q];
            s_hdr_ready[grant_q] = ready_insert;
            if (s_hdr_valid[grant_q] && ready_insert) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            valid_in         = s_valid[grant_q];
            s_ready[grant_q] = ready_in;
            if (s_valid[grant_q] && ready_in && s_last[grant_q]) begin
               rr_d    = (grant_q == CH_WD'(NUM_CH - 1)) ? '0 : grant_q + CH_WD'(1);
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant, round-robin pointer and completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Randomized bench for axis_hdr_insert_arbiter with a packet-level reference model.
module tb_axis_hdr_insert_arbiter;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int CW   = 2;
   localparam int MAXP = 64;
   localparam int MAXB = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_valid, s_last, s_ready;
   logic [N*DW-1:0] s_hdr_data, s_data;
   logic [N*BW-1:0] s_hdr_keep, s_keep;
   logic [N*CW-1:0] s_hdr_cnt;
   logic            valid_insert, ready_insert, valid_in, last_in, ready_in, busy, pkt_done;
   logic [DW-1:0]   data_insert, data_in;
   logic [BW-1:0]   keep_insert, keep_in;
   logic [CW-1:0]   byte_insert_cnt, grant_id;

   axis_hdr_insert_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
      .s_hdr_cnt(s_hdr_cnt), .s_hdr_ready(s_hdr_ready),
      .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
      .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
      .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_in(ready_in), .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   int checks, errors, cycle;

   // packet table (stimulus and expected content)
   int           p_ch [MAXP];
   int           p_start [MAXP];
   int           p_nb [MAXP];
   logic [31:0]  p_hdr [MAXP];
   logic [3:0]   p_hk [MAXP];
   logic [1:0]   p_hc [MAXP];
   logic [31:0]  p_d [MAXP][MAXB];
   logic [3:0]   p_k [MAXP][MAXB];
   bit           issued [MAXP];
   int           np, src_done;

   // per-channel source progress
   int cur [N];
   int bidx [N];
   bit hdr_done [N];
   bit hs_h [N];
   bit hs_d [N];
   bit gaps;

   // reference model of the arbiter at packet level
   bit m_free, m_in_hdr, m_done_exp;
   int m_rr, m_g;

   int          grant_log [$];
   logic [31:0] beat_log [$];
   logic [31:0] hdr_log [$];
   int          done_pulses;

   int sink_mode, hstall, dstall;
   bit pv_hdr_stall, pv_dat_stall;
   logic [31:0] pv_hdr_data, pv_data;

   task automatic add_pkt(input int ch, input int start, input int nb);
      p_ch[np] = ch; p_start[np] = start; p_nb[np] = nb;
      p_hdr[np] = $urandom; p_hk[np] = 4'($urandom); p_hc[np] = 2'($urandom);
      for (int b = 0; b < MAXB; b++) begin
         p_d[np][b] = $urandom;
         p_k[np][b] = (b == nb - 1) ? 4'($urandom_range(15, 1)) : 4'hF;
      end
      issued[np] = 1'b0;
      np++;
   endtask

   task automatic drive_sources();
      for (int c = 0; c < N; c++) begin
         int p;
         if (cur[c] < 0) begin
            for (int q = 0; q < np; q++) begin
               if (cur[c] < 0 && p_ch[q] == c && !issued[q]) begin
                  cur[c] = q; issued[q] = 1'b1; bidx[c] = 0; hdr_done[c] = 1'b0;
               end
            end
         end
         p = cur[c];
         s_hdr_valid[c] = 1'b0;
         s_hdr_data[c*DW +: DW] = $urandom;
         s_hdr_keep[c*BW +: BW] = 4'($urandom);
         s_hdr_cnt[c*CW +: CW]  = 2'($urandom);
         if (p >= 0 && !hdr_done[c] && cycle >= p_start[p]) begin
            s_hdr_valid[c] = 1'b1;
            s_hdr_data[c*DW +: DW] = p_hdr[p];
            s_hdr_keep[c*BW +: BW] = p_hk[p];
            s_hdr_cnt[c*CW +: CW]  = p_hc[p];
         end
         if (p < 0) s_valid[c] = 1'b0;
         else if (!s_valid[c] && cycle >= p_start[p]) s_valid[c] = !gaps || ($urandom_range(3) != 0);
         if (s_valid[c]) begin
            s_data[c*DW +: DW] = p_d[p][bidx[c]];
            s_keep[c*BW +: BW] = p_k[p][bidx[c]];
            s_last[c] = (bidx[c] == p_nb[p] - 1);
         end else begin
            s_data[c*DW +: DW] = $urandom;
            s_keep[c*BW +: BW] = 4'($urandom);
            s_last[c] = 1'b0;
         end
      end
   endtask

   task automatic drive_sink();
      case (sink_mode)
         0: begin ready_insert = 1'b1; ready_in = 1'b1; end
         1: begin
            ready_insert = ($urandom_range(3) != 0);
            ready_in     = ($urandom_range(3) != 0);
         end
         default: begin
            ready_insert = 1'b1; ready_in = 1'b1;
            if (!m_free && m_in_hdr && hstall > 0) begin ready_insert = 1'b0; hstall--; end
            if (!m_free && !m_in_hdr && bidx[m_g] >= 1 && dstall > 0) begin ready_in = 1'b0; dstall--; end
         end
      endcase
   endtask

   task automatic apply_hs();
      for (int c = 0; c < N; c++) begin
         if (hs_h[c]) begin hdr_done[c] = 1'b1; s_hdr_valid[c] = 1'b0; end
         if (hs_d[c] && cur[c] >= 0) begin
            s_valid[c] = 1'b0;
            bidx[c]++;
            if (bidx[c] == p_nb[cur[c]]) begin cur[c] = -1; src_done++; end
         end
         hs_h[c] = 1'b0; hs_d[c] = 1'b0;
      end
   endtask

   // Sample at negedge, compare against the model, and advance the model
   task automatic sample_and_check();
      logic [3:0] e_hr, e_r;
      int p, g;
      for (int c = 0; c < N; c++) begin
         hs_h[c] = s_hdr_valid[c] && s_hdr_ready[c];
         hs_d[c] = s_valid[c] && s_ready[c];
      end
      checks++;
      if (pkt_done !== m_done_exp) begin
         errors++; $display("FAIL pkt_done cyc %0d got %b exp %b", cycle, pkt_done, m_done_exp);
      end
      if (pkt_done === 1'b1) done_pulses++;
      m_done_exp = 1'b0;
      if (pv_hdr_stall) begin
         checks++;
         if (valid_insert !== 1'b1 || data_insert !== pv_hdr_data) begin
            errors++; $display("FAIL hdr_stall_stable cyc %0d got v=%b d=%h exp v=1 d=%h", cycle, valid_insert, data_insert, pv_hdr_data);
         end
      end
      if (pv_dat_stall) begin
         checks++;
         if (valid_in !== 1'b1 || data_in !== pv_data) begin
            errors++; $display("FAIL data_stall_stable cyc %0d got v=%b d=%h exp v=1 d=%h", cycle, valid_in, data_in, pv_data);
         end
      end
      pv_hdr_stall = valid_insert && !ready_insert; pv_hdr_data = data_insert;
      pv_dat_stall = valid_in && !ready_in;         pv_data     = data_in;

      if (m_free) begin
         checks++;
         if ({busy, valid_insert, valid_in} !== 3'b000 || s_hdr_ready !== 4'b0 || s_ready !== 4'b0) begin
            errors++; $display("FAIL idle_outputs cyc %0d got busy=%b vi=%b vd=%b hr=%b r=%b exp all 0",
                               cycle, busy, valid_insert, valid_in, s_hdr_ready, s_ready);
         end
         if (s_hdr_valid != 4'b0) begin
            for (int k = 0; k < N; k++) begin
               if (m_free && s_hdr_valid[(m_rr + k) % N]) begin
                  m_g = (m_rr + k) % N; m_free = 1'b0; m_in_hdr = 1'b1;
               end
            end
            grant_log.push_back(m_g);
         end
      end else begin
         g = m_g; p = cur[g]; e_hr = '0; e_r = '0;
         checks++;
         if (busy !== 1'b1 || grant_id !== 2'(g)) begin
            errors++; $display("FAIL grant cyc %0d got busy=%b grant=%0d exp busy=1 grant=%0d", cycle, busy, grant_id, g);
         end
         if (m_in_hdr) begin
            e_hr[g] = ready_insert;
            checks++;
            if (valid_insert !== s_hdr_valid[g] || valid_in !== 1'b0 || s_hdr_ready !== e_hr || s_ready !== 4'b0) begin
               errors++; $display("FAIL hdr_phase cyc %0d got vi=%b vd=%b hr=%b r=%b exp vi=%b vd=0 hr=%b r=0",
                                  cycle, valid_insert, valid_in, s_hdr_ready, s_ready, s_hdr_valid[g], e_hr);
            end
            if (s_hdr_valid[g] && ready_insert && p >= 0) begin
               checks++;
               if (data_insert !== p_hdr[p] || keep_insert !== p_hk[p] || byte_insert_cnt !== p_hc[p]) begin
                  errors++; $display("FAIL hdr_fields cyc %0d got %h/%h/%0d exp %h/%h/%0d", cycle,
                                     data_insert, keep_insert, byte_insert_cnt, p_hdr[p], p_hk[p], p_hc[p]);
               end
               hdr_log.push_back(data_insert);
               m_in_hdr = 1'b0;
            end
         end else begin
            e_r[g] = ready_in;
            checks++;
            if (valid_insert !== 1'b0 || valid_in !== s_valid[g] || s_ready !== e_r || s_hdr_ready !== 4'b0) begin
               errors++; $display("FAIL data_phase cyc %0d got vi=%b vd=%b hr=%b r=%b exp vi=0 vd=%b hr=0 r=%b",
                                  cycle, valid_insert, valid_in, s_hdr_ready, s_ready, s_valid[g], e_r);
            end
            if (s_valid[g] && ready_in && p >= 0) begin
               checks++;
               if (data_in !== p_d[p][bidx[g]] || keep_in !== p_k[p][bidx[g]] || last_in !== (bidx[g] == p_nb[p] - 1)) begin
                  errors++; $display("FAIL beat cyc %0d ch %0d got %h/%h/%b exp %h/%h/%b", cycle, g, data_in, keep_in,
                                     last_in, p_d[p][bidx[g]], p_k[p][bidx[g]], (bidx[g] == p_nb[p] - 1));
               end
               beat_log.push_back(data_in);
               if (bidx[g] == p_nb[p] - 1) begin
                  m_rr = (g + 1) % N; m_free = 1'b1; m_done_exp = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample_and_check();
      @(posedge clk);
      #1;
      cycle++;
      apply_hs();
      drive_sources();
      drive_sink();
   endtask

   task automatic run_until_done(input int budget, input string name);
      int n = 0;
      while (!(src_done == np && m_free) && n < budget) begin step(); n++; end
      checks++;
      if (!(src_done == np && m_free)) begin
         errors++; $display("FAIL %s_timeout got done=%0d of %0d exp all within %0d cycles", name, src_done, np, budget);
      end
      repeat (2) step();
   endtask

   task automatic model_reset();
      m_free = 1'b1; m_in_hdr = 1'b0; m_done_exp = 1'b0; m_rr = 0; m_g = 0;
      pv_hdr_stall = 1'b0; pv_dat_stall = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({valid_insert, valid_in, busy, pkt_done} !== 4'b0 || s_hdr_ready !== 4'b0 || s_ready !== 4'b0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL in_reset got vi=%b vd=%b busy=%b done=%b hr=%b r=%b g=%0d exp all 0",
                               valid_insert, valid_in, busy, pkt_done, s_hdr_ready, s_ready, grant_id);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      sink_mode = 1;
      drive_sink();
      repeat (10) begin
         step();
         checks++;
         if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
      end
   endtask

   task automatic test_single_ch2();
      int gl0 = grant_log.size();
      int bl0 = beat_log.size();
      int hl0 = hdr_log.size();
      int dp0 = done_pulses;
      int p;
      logic [31:0] exp_b [3];
      exp_b[0] = 32'h01020304; exp_b[1] = 32'h05060708; exp_b[2] = 32'h090A0B0C;
      sink_mode = 0; gaps = 1'b0;
      add_pkt(2, cycle, 3);
      p = np - 1;
      p_hdr[p] = 32'hAABBCC00; p_hk[p] = 4'b0011; p_hc[p] = 2'd1;
      for (int b = 0; b < 3; b++) begin p_d[p][b] = exp_b[b]; p_k[p][b] = 4'hF; end
      run_until_done(100, "single");
      checks++;
      if (grant_log.size() != gl0 + 1 || grant_log[gl0] != 2) begin
         errors++; $display("FAIL single_grant got n=%0d exp ch 2", grant_log.size() - gl0);
      end
      checks++;
      if (hdr_log.size() != hl0 + 1 || hdr_log[hl0] !== 32'hAABBCC00) begin
         errors++; $display("FAIL single_hdr got n=%0d exp one hdr AABBCC00", hdr_log.size() - hl0);
      end
      for (int b = 0; b < 3; b++) begin
         checks++;
         if (beat_log.size() != bl0 + 3 || beat_log[bl0 + b] !== exp_b[b]) begin
            errors++; $display("FAIL single_beat%0d got n=%0d exp %h", b, beat_log.size() - bl0, exp_b[b]);
         end
      end
      checks++;
      if (done_pulses != dp0 + 1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_done got pulses=%0d busy=%b exp 1 and 0", done_pulses - dp0, busy);
      end
   endtask

   task automatic test_rr_pair();
      int gl0 = grant_log.size();
      int exp_g [3];
      exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
      sink_mode = 1; gaps = 1'b1;
      add_pkt(0, cycle + 2, 2);
      add_pkt(1, cycle + 2, 2);
      add_pkt(0, cycle + 2, 2);
      run_until_done(300, "rr_pair");
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (grant_log.size() != gl0 + 3 || grant_log[gl0 + i] != exp_g[i]) begin
            errors++; $display("FAIL rr_pair_order%0d got n=%0d exp ch %0d", i, grant_log.size() - gl0, exp_g[i]);
         end
      end
   endtask

   task automatic test_stall();
      int bl0 = beat_log.size();
      int dp0 = done_pulses;
      sink_mode = 2; gaps = 1'b0; hstall = 2; dstall = 3;
      add_pkt(3, cycle, 5);
      run_until_done(100, "stall");
      checks++;
      if (beat_log.size() != bl0 + 5 || done_pulses != dp0 + 1 || hstall != 0 || dstall != 0) begin
         errors++; $display("FAIL stall_count got beats=%0d pulses=%0d hs=%0d ds=%0d exp 5 1 0 0",
                            beat_log.size() - bl0, done_pulses - dp0, hstall, dstall);
      end
   endtask

   task automatic test_all_continuous();
      int gl0 = grant_log.size();
      int bl0 = beat_log.size();
      int nb_tot = 0;
      sink_mode = 1; gaps = 1'b1;
      for (int i = 0; i < 8; i++) begin
         add_pkt(i % N, cycle, $urandom_range(4, 1));
         nb_tot += p_nb[np - 1];
      end
      run_until_done(600, "all4");
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (grant_log.size() != gl0 + 8 || grant_log[gl0 + i] != i % N) begin
            errors++; $display("FAIL all4_order%0d got n=%0d exp ch %0d", i, grant_log.size() - gl0, i % N);
         end
      end
      checks++;
      if (beat_log.size() != bl0 + nb_tot) begin
         errors++; $display("FAIL all4_beats got %0d exp %0d", beat_log.size() - bl0, nb_tot);
      end
   endtask

   task automatic test_random();
      int hl0 = hdr_log.size();
      sink_mode = 1; gaps = 1'b1;
      for (int i = 0; i < 24; i++) add_pkt($urandom_range(N - 1), cycle + $urandom_range(60), $urandom_range(MAXB, 1));
      run_until_done(3000, "random");
      checks++;
      if (hdr_log.size() != hl0 + 24) begin
         errors++; $display("FAIL random_pkts got %0d exp 24", hdr_log.size() - hl0);
      end
   endtask

   task automatic test_reset_mid_packet();
      int n = 0;
      int gl0;
      sink_mode = 0; gaps = 1'b0;
      add_pkt(3, cycle, 4);
      while (!(cur[3] >= 0 && bidx[3] == 1 && !m_free && !m_in_hdr) && n < 100) begin step(); n++; end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL midrst_reach got timeout exp beat 2 of ch3"); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid_insert, valid_in, busy, pkt_done} !== 4'b0 || s_hdr_ready !== 4'b0 || s_ready !== 4'b0 || grant_id !== 2'd0) begin
         errors++; $display("FAIL midrst_outputs got vi=%b vd=%b busy=%b done=%b hr=%b r=%b g=%0d exp all 0",
                            valid_insert, valid_in, busy, pkt_done, s_hdr_ready, s_ready, grant_id);
      end
      if (cur[3] >= 0) begin cur[3] = -1; src_done++; end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle++;
      drive_sources();
      drive_sink();
      gl0 = grant_log.size();
      add_pkt(1, cycle, 2);
      run_until_done(100, "midrst_after");
      checks++;
      if (grant_log.size() != gl0 + 1 || grant_log[gl0] != 1) begin
         errors++; $display("FAIL midrst_regrant got n=%0d exp one grant to ch 1", grant_log.size() - gl0);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cycle = 0; np = 0; src_done = 0; done_pulses = 0;
      gaps = 1'b0; sink_mode = 0; hstall = 0; dstall = 0;
      for (int c = 0; c < N; c++) begin cur[c] = -1; bidx[c] = 0; hdr_done[c] = 1'b0; hs_h[c] = 1'b0; hs_d[c] = 1'b0; end
      s_hdr_valid = '0; s_hdr_data = '0; s_hdr_keep = '0; s_hdr_cnt = '0;
      s_valid = '0; s_data = '0; s_keep = '0; s_last = '0;
      ready_insert = 1'b0; ready_in = 1'b0;
      model_reset();
      test_reset();
      test_single_ch2();
      test_rr_pair();
      test_stall();
      test_all_continuous();
      test_random();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
